// File: rtl/hack_pkg.sv
// hack_pkg: Hack ISA widths, instruction field positions, controller state encoding
// and the jump-condition helper shared by the CPU controller and its ALU.
package hack_pkg;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 15;

    localparam int C_BIT   = 15;
    localparam int A_BIT   = 12;
    localparam int COMP_HI = 11;
    localparam int COMP_LO = 6;
    localparam int DEST_A  = 5;
    localparam int DEST_D  = 4;
    localparam int DEST_M  = 3;
    localparam int JUMP_HI = 2;
    localparam int JUMP_LO = 0;

    typedef enum logic [2:0] {
        BOOT,
        FETCH,
        DECODE,
        MEM_RD,
        EXEC,
        MEM_WR
    } state_t;

    function automatic logic jump_taken(input logic [2:0] j, input logic zr, input logic ng);
        return (j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr);
    endfunction

endpackage

// File: rtl/hack_cpu_ctrl_alu.sv
// hack_cpu_ctrl_alu: the Hack combinational ALU (zx/nx/zy/ny/f/no) with zero and
// negative flags on its result.
module hack_cpu_ctrl_alu
    import hack_pkg::*;
(
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic              zx,
    input  logic              nx,
    input  logic              zy,
    input  logic              ny,
    input  logic              f,
    input  logic              no,
    output logic [DATA_W-1:0] out,
    output logic              zr,
    output logic              ng
);

    logic [DATA_W-1:0] xz, xn, yz, yn, fo;

    assign xz  = zx ? '0 : x;
    assign xn  = nx ? ~xz : xz;
    assign yz  = zy ? '0 : y;
    assign yn  = ny ? ~yz : yz;
    assign fo  = f ? xn + yn : xn & yn;
    assign out = no ? ~fo : fo;
    assign zr  = out == '0;
    assign ng  = out[DATA_W-1];

endmodule

// File: rtl/hack_cpu_ctrl.sv
// hack_cpu_ctrl: multi-cycle Hack CPU core holding A/D/PC, sequencing fetch, decode,
// data-memory read/write and jump evaluation around the combinational ALU.
module hack_cpu_ctrl
    import hack_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    output logic              instr_req,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic              instr_valid,
    input  logic [DATA_W-1:0] instr_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] a_reg,
    output logic [DATA_W-1:0] d_reg
);

    state_t            state, state_nx;
    logic [DATA_W-1:0] ir, m_reg, w_reg;
    logic [ADDR_W-1:0] h_reg;
    logic              zr_reg, ng_reg;
    logic [DATA_W-1:0] alu_y, alu_out;
    logic              alu_zr, alu_ng;
    logic [2:0]        jbits;

    assign alu_y = ir[A_BIT] ? m_reg : a_reg;
    assign jbits = ir[JUMP_HI:JUMP_LO];

    hack_cpu_ctrl_alu u_alu (
        .x   (d_reg),
        .y   (alu_y),
        .zx  (ir[COMP_HI]),
        .nx  (ir[COMP_HI-1]),
        .zy  (ir[COMP_HI-2]),
        .ny  (ir[COMP_HI-3]),
        .f   (ir[COMP_HI-4]),
        .no  (ir[COMP_LO]),
        .out (alu_out),
        .zr  (alu_zr),
        .ng  (alu_ng)
    );

    // Handshake outputs depend only on state and registers, never on inputs.
    assign instr_req  = state == FETCH;
    assign instr_addr = pc;
    assign mem_req    = (state == MEM_RD) || (state == MEM_WR);
    assign mem_we     = state == MEM_WR;
    assign mem_addr   = (state == MEM_WR) ? h_reg : a_reg[ADDR_W-1:0];
    assign mem_wdata  = w_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BOOT;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            BOOT:    state_nx = FETCH;
            FETCH:   state_nx = instr_valid ? DECODE : FETCH;
            DECODE:  state_nx = !ir[C_BIT] ? FETCH : ir[A_BIT] ? MEM_RD : EXEC;
            MEM_RD:  state_nx = mem_ready ? EXEC : MEM_RD;
            EXEC:    state_nx = ir[DEST_M] ? MEM_WR : FETCH;
            MEM_WR:  state_nx = mem_ready ? FETCH : MEM_WR;
            default: state_nx = BOOT;
        endcase
    end

    // H keeps the pre-write A so a jump or M write uses the address the instruction saw.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= '0;
            a_reg  <= '0;
            d_reg  <= '0;
            ir     <= '0;
            m_reg  <= '0;
            w_reg  <= '0;
            h_reg  <= '0;
            zr_reg <= 1'b0;
            ng_reg <= 1'b0;
        end else begin
            case (state)
                FETCH: if (instr_valid) ir <= instr_rdata;
                DECODE: if (!ir[C_BIT]) begin
                    a_reg <= {1'b0, ir[ADDR_W-1:0]};
                    pc    <= pc + ADDR_W'(1);
                end
                MEM_RD: if (mem_ready) m_reg <= mem_rdata;
                EXEC: begin
                    w_reg  <= alu_out;
                    h_reg  <= a_reg[ADDR_W-1:0];
                    zr_reg <= alu_zr;
                    ng_reg <= alu_ng;
                    if (ir[DEST_A]) a_reg <= alu_out;
                    if (ir[DEST_D]) d_reg <= alu_out;
                    if (!ir[DEST_M])
                        pc <= jump_taken(jbits, alu_zr, alu_ng) ? a_reg[ADDR_W-1:0] : pc + ADDR_W'(1);
                end
                MEM_WR: if (mem_ready)
                    pc <= jump_taken(jbits, zr_reg, ng_reg) ? h_reg : pc + ADDR_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// tb_hack_cpu_ctrl: runs a directed Hack program against an instruction-level model
// with configurable memory wait states, plus literal checks on key results.
module tb_hack_cpu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        instr_valid = 1'b0;
    logic [15:0] instr_rdata = '0;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        instr_req, mem_req, mem_we;
    logic [14:0] instr_addr, mem_addr, pc;
    logic [15:0] mem_wdata, a_reg, d_reg;

    int total = 0;
    int bad = 0;

    logic [15:0] imem [0:32767];
    logic [15:0] phys [0:32767];
    logic [15:0] mdl  [0:32767];
    int iw_tab [int];
    int mw_tab [int];

    hack_cpu_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_req   (instr_req),
        .instr_addr  (instr_addr),
        .instr_valid (instr_valid),
        .instr_rdata (instr_rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .pc          (pc),
        .a_reg       (a_reg),
        .d_reg       (d_reg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Hack ISA comp mnemonics expressed as plain arithmetic.
    function automatic logic [15:0] alu_model(input logic [5:0] c, input logic [15:0] x, input logic [15:0] y);
        case (c)
            6'b101010: return 16'h0000;
            6'b111111: return 16'h0001;
            6'b111010: return 16'hFFFF;
            6'b001100: return x;
            6'b110000: return y;
            6'b001101: return ~x;
            6'b110001: return ~y;
            6'b001111: return -x;
            6'b110011: return -y;
            6'b011111: return x + 16'd1;
            6'b110111: return y + 16'd1;
            6'b001110: return x - 16'd1;
            6'b110010: return y - 16'd1;
            6'b000010: return x + y;
            6'b010011: return x - y;
            6'b000111: return y - x;
            6'b000000: return x & y;
            6'b010101: return x | y;
            default:   return 16'hDEAD;
        endcase
    endfunction

    // Model state, compare process and memory responders.
    logic [14:0] m_pc, cur_pc, exp_rd_addr, exp_wr_addr;
    logic [15:0] m_a, m_d, exp_wr_data;
    logic        exp_rd, exp_wr, have_prev, prev_ireq;
    int          cyc, exp_lat, icnt, mcnt, cur_iw, cur_mw;

    initial begin
        logic [15:0] ins, y, r, old;
        logic        taken;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_instr_req", instr_req, 0);
                chk("rst_mem_req", mem_req, 0);
                chk("rst_pc", pc, 0);
                chk("rst_a", a_reg, 0);
                chk("rst_d", d_reg, 0);
                m_pc = 0; m_a = 0; m_d = 0; cur_pc = 0;
                have_prev = 0; prev_ireq = 0; exp_rd = 0; exp_wr = 0;
                cyc = 0; icnt = 0; mcnt = 0; cur_iw = 0; cur_mw = 0;
                instr_valid = 0; mem_ready = 0;
            end else begin
                cyc++;
                if (instr_req && !prev_ireq) begin
                    if (have_prev) chk("latency", cyc, exp_lat);
                    chk("retire_pc", pc, m_pc);
                    chk("retire_a", a_reg, m_a);
                    chk("retire_d", d_reg, m_d);
                    cyc = 0; have_prev = 1; cur_pc = m_pc; exp_rd = 0; exp_wr = 0;
                    ins = imem[m_pc];
                    cur_iw = iw_tab.exists(int'(m_pc)) ? iw_tab[int'(m_pc)] : 0;
                    cur_mw = mw_tab.exists(int'(m_pc)) ? mw_tab[int'(m_pc)] : 0;
                    if (!ins[15]) begin
                        m_a = {1'b0, ins[14:0]};
                        m_pc = m_pc + 15'd1;
                        exp_lat = 2 + cur_iw;
                    end else begin
                        old = m_a;
                        y = ins[12] ? mdl[old[14:0]] : old;
                        r = alu_model(ins[11:6], m_d, y);
                        exp_rd = ins[12];
                        exp_rd_addr = old[14:0];
                        if (ins[3]) begin
                            exp_wr = 1; exp_wr_addr = old[14:0]; exp_wr_data = r;
                            mdl[old[14:0]] = r;
                        end
                        if (ins[5]) m_a = r;
                        if (ins[4]) m_d = r;
                        taken = (ins[2] && $signed(r) < 0) || (ins[1] && r == 0) || (ins[0] && $signed(r) > 0);
                        m_pc = taken ? old[14:0] : m_pc + 15'd1;
                        exp_lat = 3 + cur_iw + (ins[12] ? 1 + cur_mw : 0) + (ins[3] ? 1 + cur_mw : 0);
                    end
                end
                if (instr_req) chk("instr_addr", instr_addr, cur_pc);
                if (mem_req && mem_we) begin
                    chk("wr_expected", exp_wr, 1);
                    chk("wr_addr", mem_addr, exp_wr_addr);
                    chk("wr_data", mem_wdata, exp_wr_data);
                end else if (mem_req) begin
                    chk("rd_expected", exp_rd, 1);
                    chk("rd_addr", mem_addr, exp_rd_addr);
                end
                prev_ireq = instr_req;
                instr_valid = 0;
                if (instr_req) begin
                    if (icnt >= cur_iw) begin
                        instr_valid = 1; instr_rdata = imem[instr_addr]; icnt = 0;
                    end else icnt++;
                end else icnt = 0;
                mem_ready = 0;
                if (mem_req) begin
                    if (mcnt >= cur_mw) begin
                        mem_ready = 1; mcnt = 0;
                        if (mem_we) phys[mem_addr] = mem_wdata;
                        else mem_rdata = phys[mem_addr];
                    end else mcnt++;
                end else mcnt = 0;
            end
        end
    end

    task automatic wait_fetch(input logic [14:0] addr, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(instr_req && instr_addr == addr) && n < 2000);
        if (n >= 2000) begin
            total++; bad++;
            $display("FAIL wait_fetch: no fetch of %0h within %0d cycles", addr, n);
        end
    endtask

    task automatic wait_write(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_req && mem_we) && n < 2000);
        if (n >= 2000) begin
            total++; bad++;
            $display("FAIL wait_write: no write within %0d cycles", n);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        int n;
        foreach (imem[i]) begin imem[i] = '0; phys[i] = '0; mdl[i] = '0; end
        imem[0]  = 16'h0005; imem[1]  = 16'hEC10; imem[2]  = 16'hE7D0;
        imem[3]  = 16'h0064; imem[4]  = 16'hE308; imem[5]  = 16'h0032;
        imem[6]  = 16'hFC10; imem[7]  = 16'h0014; imem[8]  = 16'hE304;
        imem[20] = 16'h0033; imem[21] = 16'hFC10; imem[22] = 16'h001E;
        imem[23] = 16'hE304; imem[24] = 16'h0064; imem[25] = 16'hFDC8;
        imem[26] = 16'h0028; imem[27] = 16'hEDE7; imem[40] = 16'h0046;
        imem[41] = 16'hEFFF; imem[70] = 16'h7FFF; imem[71] = 16'hEA87;
        imem[32767] = 16'h0003;
        phys[50] = 16'h8000; mdl[50] = 16'h8000;
        phys[51] = 16'h0001; mdl[51] = 16'h0001;
        mw_tab[4] = 3; iw_tab[6] = 1; iw_tab[25] = 2; mw_tab[25] = 1;

        #1 rst_n = 1'b0;
        #1;
        chk("reset_instr_req", instr_req, 0);
        chk("reset_mem_req", mem_req, 0);
        chk("reset_mem_we", mem_we, 0);
        chk("reset_mem_wdata", mem_wdata, 0);
        chk("reset_pc", pc, 0);
        chk("reset_a", a_reg, 0);
        chk("reset_d", d_reg, 0);
        @(negedge clk); @(negedge clk);
        #1 rst_n = 1'b1;
        #1 chk("boot_no_req", instr_req, 0);
        wait_fetch(15'd0, n);
        chk("first_fetch_delay", n, 1);

        wait_fetch(15'd3, n);
        chk("prog1_cycles", n, 8);
        chk("prog1_a", a_reg, 16'd5);
        chk("prog1_d", d_reg, 16'd6);

        wait_write(n);
        for (int k = 0; k < 4; k++) begin
            chk("mw_req", mem_req, 1);
            chk("mw_we", mem_we, 1);
            chk("mw_addr", mem_addr, 15'd100);
            chk("mw_wdata", mem_wdata, 16'd6);
            chk("mw_pc_hold", pc, 15'd4);
            @(negedge clk);
        end
        chk("mw_pc_after", pc, 15'd5);

        wait_fetch(15'd20, n);
        chk("jlt_taken_d", d_reg, 16'h8000);
        chk("jlt_taken_a", a_reg, 16'd20);
        wait_fetch(15'd24, n);
        chk("jlt_not_taken_d", d_reg, 16'd1);

        wait_fetch(15'd70, n);
        chk("old_a_jump_a", a_reg, 16'd1);
        chk("old_a_jump_d", d_reg, 16'd1);
        chk("amd_write_mem70", phys[70], 16'd1);
        chk("rmw_mem100", phys[100], 16'd7);
        wait_fetch(15'h7FFF, n);
        chk("jmp_top_a", a_reg, 16'h7FFF);
        wait_fetch(15'd0, n);
        chk("wrap_pc", pc, 15'd0);
        chk("wrap_a", a_reg, 16'd3);

        wait_write(n);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_mem_req", mem_req, 0);
        chk("abort_mem_we", mem_we, 0);
        chk("abort_wdata", mem_wdata, 0);
        chk("abort_instr_req", instr_req, 0);
        chk("abort_pc", pc, 0);
        chk("abort_a", a_reg, 0);
        chk("abort_d", d_reg, 0);
        @(negedge clk); @(negedge clk);
        #1 rst_n = 1'b1;
        #1 chk("reboot_no_req", instr_req, 0);
        wait_fetch(15'd0, n);
        chk("refetch_delay", n, 1);
        chk("refetch_addr", instr_addr, 15'd0);
        wait_fetch(15'd3, n);
        chk("rerun_cycles", n, 8);
        chk("rerun_a", a_reg, 16'd5);
        chk("rerun_d", d_reg, 16'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hack_cpu_ctrl.md
# hack_cpu_ctrl

Multi-cycle Hack CPU core: it fetches 16-bit Hack instructions, decodes them, and drives the existing combinational ALU's control bits (zx, nx, zy, ny, f, no) from the instruction's comp field. It holds the A, D and PC registers, evaluates jumps from the ALU's zr/ng flags, and talks to separate instruction and data memories through req/valid and req/ready handshakes. It sits between the memory subsystem and the ALU as the ALU's sole initiator.

## Interface
- No parameters; widths fixed by Hack ISA: 16-bit data, 15-bit address.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr_req  out  1  instruction fetch request
- instr_addr  out  15  fetch address, equal to PC
- instr_valid  in  1  instr_rdata valid; sampled only while instr_req=1
- instr_rdata  in  16  instruction word
- mem_req  out  1  data memory access request
- mem_we  out  1  1 = write, 0 = read; meaningful only while mem_req=1
- mem_addr  out  15  data address, equal to A[14:0]
- mem_wdata  out  16  write data
- mem_ready  in  1  access complete; sampled only while mem_req=1
- mem_rdata  in  16  read data, valid in the mem_ready cycle
- pc  out  15  program counter, for debug and verification
- a_reg  out  16  A register, for debug and verification
- d_reg  out  16  D register, for debug and verification

## Operation
- States: BOOT, FETCH, DECODE, MEM_RD, EXEC, MEM_WR.
- BOOT: no requests are issued. The FSM moves to FETCH on the next edge.
- FETCH: instr_req=1 and instr_addr=PC.
  - The FSM holds FETCH until instr_valid=1.
  - On that cycle it latches IR and moves to DECODE.
- DECODE, A-instruction (IR[15]=0):
  - A <= {1'b0, IR[14:0]}, PC <= PC+1, then FETCH.
- DECODE, C-instruction (IR[15]=1):
  - Goes to MEM_RD if a-bit IR[12]=1, else EXEC.
  - IR[14:13] are ignored.
- MEM_RD: mem_req=1, mem_we=0, mem_addr=A.
  - The FSM holds MEM_RD until mem_ready=1.
  - On that cycle it latches M <= mem_rdata and moves to EXEC.
- EXEC: ALU operands and controls.
  - x = D.
  - y = IR[12] ? M : A.
  - {zx,nx,zy,ny,f,no} = IR[11:6].
- EXEC register updates, all at the EXEC edge:
  - The ALU result is captured into W.
  - dest bit IR[5] writes A; dest bit IR[4] writes D.
  - The old A is captured into the jump/address holding register H.
  - If dest bit IR[3]=1 the FSM moves to MEM_WR; otherwise it performs the PC update and moves to FETCH.
- MEM_WR: mem_req=1, mem_we=1, mem_addr=H, mem_wdata=W.
  - The FSM holds MEM_WR until mem_ready=1.
  - It then performs the PC update and moves to FETCH.
- PC update:
  - Jump condition = (j1 & ng) | (j2 & zr) | (j3 & ~ng & ~zr), with j = IR[2:0].
  - zr and ng are the flags of the EXEC result; they are registered in EXEC for use in MEM_WR.
  - Jump taken: PC <= H[14:0], the A value before this instruction's write.
  - Not taken: PC <= PC+1.
- PC arithmetic: 15-bit, wraps 0x7FFF -> 0x0000. The ALU's 16-bit adder is modulo 2^16 with no carry out.

## Timing
- Reset (rst_n=0), effective immediately:
  - State = BOOT.
  - PC, A, D, IR, M, W, H = 0.
  - instr_req = mem_req = mem_we = 0.
  - mem_wdata = 0.
- The first instr_req=1 is asserted one cycle after the first rising edge following deassertion.
- All handshake outputs decode from state and registers; none are combinational from inputs.
- Address and data are stable while a request is held.
- A valid/ready response in the same cycle as the request is legal: zero-wait access.
- Minimum latency per instruction, with zero-wait memory:
  - A-instruction: 2 cycles.
  - C-instruction without M: 3 cycles.
  - C-instruction with M read: 4 cycles.
  - C-instruction with M write: +1 cycle.
- Each wait cycle adds 1 cycle.
- Read-modify-write of M (for example M=M+1): MEM_RD and MEM_WR both use the old A.
- Reset mid-transaction aborts it: requests drop asynchronously, and there is no partial register update.

## Structure
- Shared package hack_pkg holds:
  - state encoding;
  - IR field positions (a-bit, comp, dest, jump);
  - ISA widths (DATA_W=16, ADDR_W=15).
- One sub-module: the existing ALU, instantiated unchanged.
- Jump evaluation is a function in hack_pkg.

## Test plan
- Reset then release with zero-wait memories -> BOOT, then instr_req=1 with instr_addr=0; pc=0, a_reg=0, d_reg=0.
- Program 0x0005, 0xEC10 (D=A), 0xE7D0 (D=D+1) -> a_reg=5, d_reg=6, pc=3; cycle count 2+3+3.
- Load A=100 (0x0064), then 0xE308 (M=D, D=6) with mem_ready held low 3 cycles -> mem_req, mem_we, mem_addr=100 and mem_wdata=6 all stable through the wait; pc advances only after ready.
- 0xFC10 (D=M) with mem_rdata=0x8000, then A=20 (0x0014), then 0xE304 (D;JLT) -> d_reg=0x8000, jump taken, pc=20. Repeat with mem_rdata=0x0001 -> jump not taken, pc=+1.
- A=0x7FFF then 0xEA87 (0;JMP) -> pc=0x7FFF. The A-instruction fetched there -> pc wraps to 0.
- Assert rst_n=0 during MEM_WR wait -> mem_req=0 immediately; all registers cleared; restart fetches address 0.
